// File: rtl/axis_write_pack_pkg.sv
// axis_write_pack shared definitions: one-hot state indices,
// state encoding and the lane-count to byte-strobe helper.
package axis_write_pack_pkg;

   localparam int IDLE   = 0;
   localparam int ACTIVE = 1;
   localparam int FLUSH  = 2;
   localparam int DONE   = 3;

   localparam int STRB_MAX = 128;

   typedef enum logic [3:0] {
      S_IDLE   = 4'b0001,
      S_ACTIVE = 4'b0010,
      S_FLUSH  = 4'b0100,
      S_DONE   = 4'b1000
   } state_t;

   // Byte enables for the lowest `lanes` lanes of a beat.
   function automatic logic [STRB_MAX-1:0] strb_mask(
      input int lanes,
      input int lane_bytes
   );
      logic [STRB_MAX-1:0] m;
      m = '0;
      for (int i = 0; i < STRB_MAX; i++)
         m[i] = (i < lanes * lane_bytes);
      return m;
   endfunction

endpackage

// File: rtl/fifo_simple.sv
// Synchronous FIFO, first-word fall-through read port.
// Ports: wr_en/wr_data push, rd_en pop, rd_data head, empty/full/count.
module fifo_simple #(
   parameter int DATA_WIDTH = 32,
   parameter int AWIDTH     = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  full,
   output logic [AWIDTH:0]       count
);

   localparam int DEPTH = 2 ** AWIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AWIDTH-1:0]     r_wr_ptr;
   logic [AWIDTH-1:0]     r_rd_ptr;
   logic [AWIDTH:0]       r_cnt;
   logic                  w_wr;
   logic                  w_rd;

   assign empty   = (r_cnt == '0);
   assign full    = (r_cnt == (AWIDTH+1)'(DEPTH));
   assign count   = r_cnt;
   assign rd_data = r_mem[r_rd_ptr];
   assign w_wr    = wr_en & ~full;
   assign w_rd    = rd_en & ~empty;

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
         if (w_rd)
            r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
         case ({w_wr, w_rd})
            2'b10:   r_cnt <= r_cnt + (AWIDTH+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AWIDTH+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/axis_write_pack.sv
// Packs narrow upstream words into wide AXI write beats with strobes,
// wlast per burst/stream end, and a done pulse.
// Ports: cfg_* configure a transfer, data/valid/ready upstream,
// axi_w* AXI write-data channel, done completion pulse.
module axis_write_pack
   import axis_write_pack_pkg::*;
#(
   parameter int BUF_AWIDTH     = 9,
   parameter int CONFIG_DWIDTH  = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int WIDTH_RATIO    = 2,
   parameter int AXI_LEN_WIDTH  = 8,
   parameter int AXI_DATA_WIDTH = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [CONFIG_DWIDTH-1:0]    cfg_length,
   input  logic [AXI_LEN_WIDTH-1:0]    cfg_burst,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
   output logic                        axi_wlast,
   output logic                        axi_wvalid,
   input  logic                        axi_wready,
   input  logic [DATA_WIDTH-1:0]       data,
   input  logic                        valid,
   output logic                        ready,
   output logic                        done
);

   localparam int STRB_W     = AXI_DATA_WIDTH / 8;
   localparam int FILL_W     = $clog2(WIDTH_RATIO) + 1;
   localparam int LANE_BYTES = DATA_WIDTH / 8;
   localparam logic [BUF_AWIDTH:0] HALF =
      (BUF_AWIDTH+1)'(2 ** (BUF_AWIDTH - 1));

   state_t                     r_state;
   state_t                     w_state_next;
   logic [3:0]                 w_st;

   logic [CONFIG_DWIDTH-1:0]   r_len;
   logic [AXI_LEN_WIDTH-1:0]   r_burst;
   logic [CONFIG_DWIDTH-1:0]   r_in_cnt;
   logic [CONFIG_DWIDTH-1:0]   r_pop_cnt;
   logic [AXI_LEN_WIDTH-1:0]   r_bcnt;
   logic [AXI_DATA_WIDTH-1:0]  r_acc;
   logic [FILL_W-1:0]          r_fill;

   logic [AXI_DATA_WIDTH-1:0]  r_wdata;
   logic [STRB_W-1:0]          r_wstrb;
   logic                       r_wlast;
   logic                       r_wvalid;
   logic                       r_ready;

   logic                       w_fifo_rst;
   logic                       w_push;
   logic                       w_pop;
   logic [DATA_WIDTH-1:0]      w_rd_data;
   logic                       w_empty;
   logic                       w_full;
   logic [BUF_AWIDTH:0]        w_count;
   logic                       w_final;
   logic                       w_beat_done;
   logic                       w_load;
   logic                       w_last;
   logic                       w_accept;
   logic [AXI_DATA_WIDTH-1:0]  w_beat;
   logic [STRB_W-1:0]          w_strb;

   assign w_st       = r_state;
   assign cfg_ready  = w_st[IDLE];
   assign done       = w_st[DONE];
   assign axi_wdata  = r_wdata;
   assign axi_wstrb  = r_wstrb;
   assign axi_wlast  = r_wlast;
   assign axi_wvalid = r_wvalid;
   assign ready      = r_ready;

   // Buffer is held empty whenever no transfer is configured.
   assign w_fifo_rst = rst | w_st[IDLE];

   assign w_push = valid & w_st[ACTIVE] & ~w_full
                 & (r_in_cnt != r_len);

   // Pop only when the output slot is free or emptying this cycle.
   assign w_pop = w_st[ACTIVE] & ~w_empty
                & (~r_wvalid | axi_wready);

   assign w_final     = (r_pop_cnt == r_len - CONFIG_DWIDTH'(1));
   assign w_beat_done = w_final
                      | (r_fill == FILL_W'(WIDTH_RATIO - 1));
   assign w_load      = w_pop & w_beat_done;
   assign w_last      = w_final | (r_bcnt == r_burst);
   assign w_accept    = r_wvalid & axi_wready;

   assign w_strb = STRB_W'(strb_mask(int'(r_fill) + 1, LANE_BYTES));

   always_comb begin
      w_beat = r_acc;
      for (int k = 0; k < WIDTH_RATIO; k++) begin
         if (FILL_W'(k) == r_fill)
            w_beat[k*DATA_WIDTH +: DATA_WIDTH] = w_rd_data;
      end
   end

   fifo_simple #(
      .DATA_WIDTH (DATA_WIDTH),
      .AWIDTH     (BUF_AWIDTH)
   ) u_buf (
      .clk     (clk),
      .rst     (w_fifo_rst),
      .wr_en   (w_push),
      .wr_data (data),
      .rd_en   (w_pop),
      .rd_data (w_rd_data),
      .empty   (w_empty),
      .full    (w_full),
      .count   (w_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   // In FLUSH the output slot holds only the final beat, so its
   // wlast marks stream completion.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (cfg_valid)
               w_state_next = (cfg_length != '0) ? S_ACTIVE : S_DONE;
         end
         S_ACTIVE: begin
            if (w_pop && w_final)
               w_state_next = S_FLUSH;
         end
         S_FLUSH: begin
            if (w_accept && r_wlast)
               w_state_next = S_DONE;
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len     <= '0;
         r_burst   <= '0;
         r_in_cnt  <= '0;
         r_pop_cnt <= '0;
         r_bcnt    <= '0;
         r_acc     <= '0;
         r_fill    <= '0;
      end else begin
         if (w_st[IDLE] && cfg_valid) begin
            r_len     <= cfg_length;
            r_burst   <= cfg_burst;
            r_in_cnt  <= '0;
            r_pop_cnt <= '0;
            r_bcnt    <= '0;
            r_acc     <= '0;
            r_fill    <= '0;
         end
         if (w_push)
            r_in_cnt <= r_in_cnt + CONFIG_DWIDTH'(1);
         if (w_pop) begin
            r_pop_cnt <= r_pop_cnt + CONFIG_DWIDTH'(1);
            if (w_beat_done) begin
               r_acc  <= '0;
               r_fill <= '0;
            end else begin
               r_acc  <= w_beat;
               r_fill <= r_fill + FILL_W'(1);
            end
         end
         if (w_load)
            r_bcnt <= w_last ? '0 : r_bcnt + AXI_LEN_WIDTH'(1);
      end
   end

   // Output beat register; cleared once accepted with no successor.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_wlast  <= 1'b0;
         r_wvalid <= 1'b0;
      end else if (w_load) begin
         r_wdata  <= w_beat;
         r_wstrb  <= w_strb;
         r_wlast  <= w_last;
         r_wvalid <= 1'b1;
      end else if (w_accept) begin
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_wlast  <= 1'b0;
         r_wvalid <= 1'b0;
      end
   end

   // Ready lags the buffer count by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ready <= 1'b0;
      else
         r_ready <= (w_state_next == S_ACTIVE) && (w_count < HALF);
   end

endmodule
